dwconv_seq_ctrl: RTL and testbench



---
 rtl/dwconv_pkg.sv | 19 +
 rtl/dwconv_pos_cnt.sv | 50 +++++
 rtl/dwconv_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_dwconv_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwconv_pkg.sv
// Shared types and sizing for the depthwise 3x3 sequencer.
// Holds the FSM encoding and the fixed counter and tag widths.
package dwconv_pkg;

    localparam int CNT_W       = 5;
    localparam int POS_W       = 4;
    localparam int NUM_CH_DEF  = 32;
    localparam int NUM_POS_DEF = 9;
    localparam int FM_AW_DEF   = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WLOAD = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dwconv_pos_cnt.sv
// Nested channel/position counter for the sequencer.
// It freezes on hold, clears on clr, advances on adv, and exports the window address.
module dwconv_pos_cnt
    import dwconv_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int NUM_POS = NUM_POS_DEF,
    parameter int FM_AW   = FM_AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             clr,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output logic [POS_W-1:0] pos,
    output logic             pos_wrap,
    output logic             cnt_last,
    output logic [FM_AW-1:0] addr
);

    assign pos_wrap = (pos == POS_W'(NUM_POS - 1));
    assign cnt_last = (cnt == CNT_W'(NUM_CH - 1));
    assign addr     = FM_AW'(cnt) * FM_AW'(NUM_POS) + FM_AW'(pos);

    // Counter update: hold has priority over clear and advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pos <= '0;
        end else if (hold) begin
            cnt <= cnt;
            pos <= pos;
        end else if (clr) begin
            cnt <= '0;
            pos <= '0;
        end else if (adv) begin
            if (pos_wrap) begin
                pos <= '0;
                cnt <= cnt_last ? CNT_W'(0) : cnt + CNT_W'(1);
            end else begin
                pos <= pos + POS_W'(1);
            end
        end else begin
            cnt <= cnt;
            pos <= pos;
        end
    end

endmodule

// File: rtl/dwconv_seq_ctrl.sv
// Layer sequencer for the depthwise 3x3 MAC array: weight/window fetch,
// MAC enable with tags, and a stall-frozen valid/ready result stage.
module dwconv_seq_ctrl
    import dwconv_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int NUM_POS = NUM_POS_DEF,
    parameter int FM_AW   = FM_AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             wt_rd_en,
    output logic [CNT_W-1:0] wt_addr,
    output logic             wt_load,
    output logic             fm_rd_en,
    output logic [FM_AW-1:0] fm_addr,
    output logic             mac_en,
    output logic [CNT_W-1:0] cnt_in,
    output logic [POS_W-1:0] pos_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_cnt,
    output logic [POS_W-1:0] out_pos
);

    state_t           state;
    state_t           state_nxt;
    logic             stall;
    logic             cnt_clr;
    logic             issue;
    logic             pos_wrap;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt;
    logic [POS_W-1:0] pos;
    logic             mac_v;
    logic             wt_load_r;

    assign stall = out_valid & ~out_ready;

    dwconv_pos_cnt #(
        .NUM_CH  (NUM_CH),
        .NUM_POS (NUM_POS),
        .FM_AW   (FM_AW)
    ) u_pos_cnt (
        .clk      (clk),
        .rst      (rst),
        .hold     (stall),
        .clr      (cnt_clr),
        .adv      (issue),
        .cnt      (cnt),
        .pos      (pos),
        .pos_wrap (pos_wrap),
        .cnt_last (cnt_last),
        .addr     (fm_addr)
    );

    // State register; a stalled cycle leaves the FSM where it is.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (!stall) begin
            state <= state_nxt;
        end else begin
            state <= state;
        end
    end

    // Next state and fetch strobes; strobes are suppressed whenever the output stalls.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        issue     = 1'b0;
        wt_rd_en  = 1'b0;
        fm_rd_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_WLOAD;
                    cnt_clr   = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WLOAD: begin
                wt_rd_en  = ~stall;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                issue    = ~stall;
                fm_rd_en = ~stall;
                if (pos_wrap) begin
                    state_nxt = cnt_last ? ST_DRAIN : ST_WLOAD;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!mac_v && (!out_valid || out_ready)) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Issue -> MAC -> output pipeline; the whole chain freezes together on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            wt_load_r <= 1'b0;
            mac_v     <= 1'b0;
            cnt_in    <= '0;
            pos_in    <= '0;
            out_valid <= 1'b0;
            out_cnt   <= '0;
            out_pos   <= '0;
        end else if (!stall) begin
            wt_load_r <= wt_rd_en;
            mac_v     <= fm_rd_en;
            cnt_in    <= cnt;
            pos_in    <= pos;
            out_valid <= mac_v;
            out_cnt   <= cnt_in;
            out_pos   <= pos_in;
        end else begin
            wt_load_r <= wt_load_r;
            mac_v     <= mac_v;
            cnt_in    <= cnt_in;
            pos_in    <= pos_in;
            out_valid <= out_valid;
            out_cnt   <= out_cnt;
            out_pos   <= out_pos;
        end
    end

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign wt_addr = cnt;
    assign wt_load = wt_load_r & ~stall;
    assign mac_en  = mac_v & ~stall;

endmodule

// File: tb/tb_dwconv_seq_ctrl.sv
// Directed self-checking bench for dwconv_seq_ctrl: full layers, stalls,
// start while busy, mid-run reset, and a reduced-size instance.
module tb_dwconv_seq_ctrl;

    localparam int NCH  = 32;
    localparam int NPOS = 9;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       wt_rd_en;
    logic [4:0] wt_addr;
    logic       wt_load;
    logic       fm_rd_en;
    logic [8:0] fm_addr;
    logic       mac_en;
    logic [4:0] cnt_in;
    logic [3:0] pos_in;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_cnt;
    logic [3:0] out_pos;

    logic       s_start;
    logic       s_busy;
    logic       s_done;
    logic       s_wt_rd_en;
    logic [4:0] s_wt_addr;
    logic       s_wt_load;
    logic       s_fm_rd_en;
    logic [3:0] s_fm_addr;
    logic       s_mac_en;
    logic [4:0] s_cnt_in;
    logic [3:0] s_pos_in;
    logic       s_out_valid;
    logic [4:0] s_out_cnt;
    logic [3:0] s_out_pos;

    int cyc;
    int total;
    int fails;

    dwconv_seq_ctrl #(.NUM_CH(32), .NUM_POS(9), .FM_AW(9)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_load(wt_load),
        .fm_rd_en(fm_rd_en), .fm_addr(fm_addr), .mac_en(mac_en),
        .cnt_in(cnt_in), .pos_in(pos_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_cnt(out_cnt), .out_pos(out_pos)
    );

    dwconv_seq_ctrl #(.NUM_CH(2), .NUM_POS(3), .FM_AW(4)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .wt_rd_en(s_wt_rd_en), .wt_addr(s_wt_addr), .wt_load(s_wt_load),
        .fm_rd_en(s_fm_rd_en), .fm_addr(s_fm_addr), .mac_en(s_mac_en),
        .cnt_in(s_cnt_in), .pos_in(s_pos_in), .out_valid(s_out_valid),
        .out_ready(1'b1), .out_cnt(s_out_cnt), .out_pos(s_out_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {25'd0, busy, done, wt_rd_en, wt_load, fm_rd_en, mac_en, out_valid}, 32'd0);
        chk({tag, "_addr"}, {18'd0, wt_addr, fm_addr}, 32'd0);
        chk({tag, "_tags"}, {14'd0, cnt_in, pos_in, out_cnt, out_pos}, 32'd0);
    endtask

    // Pulse start and check the first three cycles of a layer.
    task automatic launch();
        start = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        #1;
        chk("c1_busy", busy, 1);
        chk("c1_wt_rd_en", wt_rd_en, 1);
        chk("c1_wt_addr", wt_addr, 0);
        chk("c1_fm_rd_en", fm_rd_en, 0);
        tick();
        #1;
        chk("c2_fm_rd_en", fm_rd_en, 1);
        chk("c2_fm_addr", fm_addr, 0);
        chk("c2_wt_load", wt_load, 1);
        tick();
        #1;
        chk("c3_mac_en", mac_en, 1);
        chk("c3_cnt_pos_in", {cnt_in, pos_in}, 0);
        chk("c3_out_valid", out_valid, 0);
    endtask

    // Run the rest of a layer from cycle 4, tracking every strobe and tag.
    task automatic run_loop(input int stall_cyc, input int stall_len, input logic [8:0] stall_tag,
                            input int start_cyc, input int abort_cyc,
                            output int done_cyc, output int beats, output int wloads, output int wreads);
        int iss_c, iss_p, mac_c, mac_p, oc, op, left;
        logic [8:0] hold_tag;
        bit fin;
        iss_c = 0; iss_p = 2; mac_c = 0; mac_p = 1; oc = 0; op = 0;
        beats = 0; wloads = 1; wreads = 1; done_cyc = -1; left = 0;
        hold_tag = 9'd0; fin = 1'b0;
        for (int k = 0; k < 600 && !fin; k++) begin
            tick();
            start = (cyc == start_cyc);
            if (cyc == stall_cyc) left = stall_len;
            out_ready = (left == 0);
            if (cyc == abort_cyc) rst = 1'b1;
            #1;
            chk("run_busy", busy, 1);
            if (left > 0) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_strobes", {wt_rd_en, fm_rd_en, wt_load, mac_en}, 0);
                if (left == stall_len) begin
                    hold_tag = {out_cnt, out_pos};
                    chk("stall_tag_start", {out_cnt, out_pos}, stall_tag);
                end else begin
                    chk("stall_tag_hold", {out_cnt, out_pos}, hold_tag);
                end
                left--;
            end
            if (wt_rd_en) begin
                chk("wt_addr", wt_addr, wreads);
                wreads++;
            end
            if (fm_rd_en) begin
                chk("fm_addr", fm_addr, iss_c * NPOS + iss_p);
                if (iss_p == NPOS - 1) begin iss_p = 0; iss_c++; end else iss_p++;
            end
            if (mac_en) begin
                chk("mac_cnt_in", cnt_in, mac_c);
                chk("mac_pos_in", pos_in, mac_p);
                if (mac_p == NPOS - 1) begin mac_p = 0; mac_c++; end else mac_p++;
            end
            if (wt_load) wloads++;
            if (out_valid && out_ready) begin
                chk("out_cnt", out_cnt, oc);
                chk("out_pos", out_pos, op);
                beats++;
                if (op == NPOS - 1) begin op = 0; oc++; end else op++;
            end
            if (done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end
            if (cyc == abort_cyc) fin = 1'b1;
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int dc, bt, wl, wr, sc, sp, oc, op, sbeats, sdone;
        bit fin;
        total = 0; fails = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; s_start = 1'b0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk_zero("reset");

        // Nominal layer
        launch();
        run_loop(-1, 0, 9'd0, -1, -1, dc, bt, wl, wr);
        chk("nom_done_cyc", dc, 323);
        chk("nom_beats", bt, 288);
        chk("nom_wt_load", wl, 32);
        chk("nom_wt_rd", wr, 32);
        tick(); #1;
        chk("nom_idle_busy", busy, 0);
        chk("nom_single_done", done, 0);

        // Start while busy is ignored; start right after done launches again
        launch();
        run_loop(-1, 0, 9'd0, 50, -1, dc, bt, wl, wr);
        chk("sb_done_cyc", dc, 323);
        chk("sb_beats", bt, 288);
        tick(); #1;
        chk("sb_idle_busy", busy, 0);
        chk("sb_single_done", done, 0);

        // Backpressure: 5 stalled cycles while tag (3,4) is presented
        launch();
        run_loop(38, 5, {5'd3, 4'd4}, -1, -1, dc, bt, wl, wr);
        chk("bp_done_cyc", dc, 328);
        chk("bp_beats", bt, 288);
        chk("bp_wt_load", wl, 32);
        tick(); #1;

        // Stall during the channel-1 weight load cycle
        launch();
        run_loop(11, 1, {5'd0, 4'd7}, -1, -1, dc, bt, wl, wr);
        chk("cb_done_cyc", dc, 324);
        chk("cb_beats", bt, 288);
        chk("cb_wt_load", wl, 32);
        chk("cb_wt_rd", wr, 32);
        tick(); #1;

        // Reset in cycle 100 aborts the layer
        launch();
        run_loop(-1, 0, 9'd0, -1, 100, dc, bt, wl, wr);
        chk("abort_no_done", dc, -1);
        tick();
        rst = 1'b0;
        #1;
        chk_zero("abort");
        for (int k = 0; k < 10; k++) begin
            tick(); #1;
            chk("abort_quiet", {busy, done}, 0);
        end
        launch();
        run_loop(-1, 0, 9'd0, -1, -1, dc, bt, wl, wr);
        chk("rerun_done_cyc", dc, 323);
        chk("rerun_beats", bt, 288);
        tick(); #1;

        // Reduced instance: 2 channels x 3 positions
        sc = 0; sp = 0; oc = 0; op = 0; sbeats = 0; sdone = -1; fin = 1'b0;
        s_start = 1'b1;
        cyc = 0;
        for (int k = 0; k < 40 && !fin; k++) begin
            tick();
            s_start = 1'b0;
            #1;
            if (s_fm_rd_en) begin
                chk("s_fm_addr", s_fm_addr, sc * 3 + sp);
                if (sp == 2) begin sp = 0; sc++; end else sp++;
            end
            if (s_out_valid) begin
                chk("s_out_cnt", s_out_cnt, oc);
                chk("s_out_pos", s_out_pos, op);
                sbeats++;
                if (op == 2) begin op = 0; oc++; end else op++;
            end
            if (s_done) begin
                sdone = cyc;
                fin = 1'b1;
            end
        end
        chk("s_done_cyc", sdone, 11);
        chk("s_beats", sbeats, 6);
        tick(); #1;
        chk("s_idle_busy", s_busy, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
